fmab_vec: RTL
=============

// Module: fmab_vec
// PURPOSE
//  Parametrised successor of the 4-lane bf16 multiply-accumulate block: LANES independent lanes, each multiplying
//  one bf16-style pair per beat and accumulating into a signed block-floating accumulator (mantissa + exponent).
//  Adds valid/ready input and output handshakes and sequence framing (in_last) with automatic accumulator restart.
//  Sits between the operand streamer and the result normaliser in the dot-product datapath.
// PARAMETERS
//  LANES  4   number of independent MAC lanes
//  EW     8   operand exponent width (bias 2^(EW-1)-1)
//  MW     7   operand explicit mantissa width (hidden 1 added internally)
//  ACCW   32  signed accumulator mantissa width; must be >= 2*MW+4
// PORTS
//  clk        in   1              clock, all state on rising edge
//  reset      in   1              asynchronous, active-high; clears all state
//  in_valid   in   1              operand beat valid
//  in_ready   out  1              block accepts beat when in_valid & in_ready
//  in_last    in   1              beat closes the current sequence
//  op_a       in   LANES*(1+EW+MW) lane i operand A at [i*(1+EW+MW) +: 1+EW+MW], {sign,exp,man}
//  op_b       in   LANES*(1+EW+MW) lane i operand B, same packing
//  out_valid  out  1              result held valid
//  out_ready  in   1              downstream accepts result when out_valid & out_ready
//  out_acc    out  LANES*ACCW     per-lane signed accumulator mantissa
//  out_exp    out  LANES*(EW+2)   per-lane accumulator exponent (sum of two biased exps)
// BEHAVIOUR
//  - Reset: in_ready=1 after release, out_valid=0, out_acc=0, out_exp=0, pipeline valids=0, all lanes empty.
//  - Pipeline: S1 (registered on accept) = P={1,ma}*{1,mb} (2*MW+2 bits, unsigned), e_p=ea+eb, s_p=sa^sb,
//    zero flag z=(ea==0)|(eb==0). S2 (next edge) = align/add into lane accumulator. Latency accept->acc = 2 edges.
//  - Lane value = acc * 2^(exp - 2*bias - 2*MW). Empty lane: first non-zero product loads acc=±P, exp=e_p.
//  - Align: e_new=max(exp,e_p); acc >>>= (e_new-exp), P >>= (e_new-e_p); shift >= ACCW gives acc 0/-1, P 0.
//    Truncation (toward -inf), no rounding, no sticky.
//  - Add: sum = acc ± P (minus when s_p=1), computed in ACCW+1 bits; if sum does not fit ACCW signed,
//    sum>>>=1 and e_new+=1 (one-step renormalise). Zero-flag product leaves acc/exp unchanged.
//  - Sum exactly 0 keeps exp; lane stays non-empty. Lanes never interact.
//  - in_ready = !out_valid & !(S1 valid & S1 last). One bubble after each last beat; no stall mid-sequence.
//  - When S2 processes a last beat: out_acc/out_exp <= post-add values, out_valid<=1, all lanes marked
//    empty (acc=0, exp=0) on the same edge; next accepted beat starts a new sequence.
//  - out_valid held with stable data until out_valid & out_ready; clears on that edge; in_ready rises next cycle.
//  - in_last with all-zero products: out_acc=0, out_exp=0 for that lane.
//  - Single-beat sequence (first beat has in_last) valid: result = ±P, e_p.
//  - op_a/op_b/in_last ignored when !(in_valid & in_ready); S1 valid cleared when no accept.
//  - Reset mid-sequence or with out_valid=1 discards everything; no partial result emitted.
// TESTING
//  1 LANES=4 default; 3 beats 0x3F80*0x3F80 all lanes, last on 3rd -> out_acc=0x0000C000, out_exp=254 every lane.
//  2 lane0 beats 0x4000*0x3F80 then 0x3F80*0x3F80 (last) -> lane0 out_acc=0x6000, out_exp=255.
//  3 lane1 0x3F80*0xBF80 single last beat -> out_acc=0xFFFFC000 (-0x4000), out_exp=254; lane2 op 0x0000 -> 0, 0.
//  4 ACCW=18: 8 beats 0x3F80*0x3F80, last on 8th -> overflow renormalise: out_acc=0x10000, out_exp=255.
//  5 out_ready=0 for 5 cycles after out_valid -> out_valid/data stable, in_ready=0; ready=1 -> in_ready=1 next cycle.
//  6 assert reset during beat 2 of sequence -> out_valid=0, out_acc=0; new 1-beat 0x3F80*0x3F80 -> 0x4000, 254.

Source files
------------

// File: rtl/fmab_vec.sv
// fmab_vec: multi-lane bf16-style multiply-accumulate with block-floating accumulators.
//
// Each of LANES independent lanes multiplies one {sign,exp,man} operand pair per accepted
// beat and folds the product into a signed accumulator mantissa with its own exponent.
// A beat flagged with in_last closes the sequence: the post-add lane values are latched
// into the output registers, held until taken downstream, and the lanes restart empty.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     operand beat handshake; in_last marks the closing beat
//   op_a, op_b            packed lane operands, lane i at [i*(1+EW+MW) +: 1+EW+MW]
//   out_valid/out_ready   result handshake; data held stable while out_valid & !out_ready
//   out_acc               per-lane signed accumulator mantissa (ACCW bits each)
//   out_exp               per-lane accumulator exponent (EW+2 bits each, sum of biased exps)
module fmab_vec #(
    parameter int LANES = 4,
    parameter int EW    = 8,
    parameter int MW    = 7,
    parameter int ACCW  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [LANES*(1+EW+MW)-1:0]    op_a,
    input  logic [LANES*(1+EW+MW)-1:0]    op_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*ACCW-1:0]         out_acc,
    output logic [LANES*(EW+2)-1:0]       out_exp
);

    localparam int OW = 1 + EW + MW;   // packed operand width
    localparam int PW = 2 * MW + 2;    // unsigned product width
    localparam int XW = EW + 2;        // accumulator exponent width

    // Stage 1 registers (product of the accepted beat)
    logic                        vld_p1_q, vld_p1_d;
    logic                        last_p1_q, last_p1_d;
    logic        [PW-1:0]        prod_p1_q [LANES];
    logic        [PW-1:0]        prod_p1_d [LANES];
    logic        [XW-1:0]        exp_p1_q  [LANES];
    logic        [XW-1:0]        exp_p1_d  [LANES];
    logic                        sgn_p1_q  [LANES];
    logic                        sgn_p1_d  [LANES];
    logic                        zero_p1_q [LANES];
    logic                        zero_p1_d [LANES];

    // Lane accumulators and held result
    logic signed [ACCW-1:0]      acc_q   [LANES];
    logic signed [ACCW-1:0]      acc_d   [LANES];
    logic        [XW-1:0]        exp_q   [LANES];
    logic        [XW-1:0]        exp_d   [LANES];
    logic                        empty_q [LANES];
    logic                        empty_d [LANES];
    logic                        out_valid_q, out_valid_d;
    logic        [LANES*ACCW-1:0] out_acc_q, out_acc_d;
    logic        [LANES*XW-1:0]   out_exp_q, out_exp_d;

    logic accept;

    // Arithmetic right shift; shifting by the full width or more leaves only the sign.
    function automatic logic signed [ACCW-1:0] sra_acc(input logic signed [ACCW-1:0] v,
                                                       input logic [XW-1:0] sh);
        if (int'(sh) >= ACCW) return v[ACCW-1] ? '1 : '0;
        return v >>> sh;
    endfunction

    // Logical right shift of the unsigned product (truncating).
    function automatic logic [PW-1:0] srl_prod(input logic [PW-1:0] p, input logic [XW-1:0] sh);
        if (int'(sh) >= PW) return '0;
        return p >> sh;
    endfunction

    // One-step renormalise: a sum that no longer fits ACCW signed is halved.
    function automatic logic signed [ACCW-1:0] renorm(input logic signed [ACCW:0] s);
        return (s[ACCW] ^ s[ACCW-1]) ? s[ACCW:1] : s[ACCW-1:0];
    endfunction

    // A closing beat in stage 1 blocks the next accept, leaving one bubble so the
    // restart and the output latch never overlap with a new sequence's first beat.
    assign in_ready  = !out_valid_q && !(vld_p1_q && last_p1_q);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_exp   = out_exp_q;

    always_comb begin
        logic        [OW-1:0]   opa, opb;
        logic        [PW-1:0]   xa, xb;
        logic        [XW-1:0]   e_new;
        logic signed [ACCW-1:0] acc_al;
        logic        [PW-1:0]   p_al;
        logic signed [ACCW:0]   acc_ext, p_ext, sum;
        logic signed [ACCW-1:0] p_load;
        logic signed [ACCW-1:0] acc_post;
        logic        [XW-1:0]   exp_post;
        logic                   emp_post;
        logic                   ovf;

        opa = '0; opb = '0; xa = '0; xb = '0; e_new = '0; acc_al = '0; p_al = '0;
        acc_ext = '0; p_ext = '0; sum = '0; p_load = '0; acc_post = '0; exp_post = '0;
        emp_post = 1'b0; ovf = 1'b0;

        // Stage 0 -> 1: form products of the accepted beat
        vld_p1_d  = accept;
        last_p1_d = last_p1_q;
        prod_p1_d = prod_p1_q;
        exp_p1_d  = exp_p1_q;
        sgn_p1_d  = sgn_p1_q;
        zero_p1_d = zero_p1_q;
        if (accept) begin
            last_p1_d = in_last;
            for (int i = 0; i < LANES; i++) begin
                opa = op_a[i*OW +: OW];
                opb = op_b[i*OW +: OW];
                xa  = {{(PW-MW-1){1'b0}}, 1'b1, opa[MW-1:0]};
                xb  = {{(PW-MW-1){1'b0}}, 1'b1, opb[MW-1:0]};
                prod_p1_d[i] = xa * xb;
                exp_p1_d[i]  = {2'b00, opa[OW-2 -: EW]} + {2'b00, opb[OW-2 -: EW]};
                sgn_p1_d[i]  = opa[OW-1] ^ opb[OW-1];
                zero_p1_d[i] = (opa[OW-2 -: EW] == '0) || (opb[OW-2 -: EW] == '0);
            end
        end

        // Stage 1 -> 2: align, add, renormalise into the lane accumulators
        acc_d       = acc_q;
        exp_d       = exp_q;
        empty_d     = empty_q;
        out_acc_d   = out_acc_q;
        out_exp_d   = out_exp_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (vld_p1_q) begin
            for (int i = 0; i < LANES; i++) begin
                e_new   = (exp_q[i] > exp_p1_q[i]) ? exp_q[i] : exp_p1_q[i];
                acc_al  = sra_acc(acc_q[i], e_new - exp_q[i]);
                p_al    = srl_prod(prod_p1_q[i], e_new - exp_p1_q[i]);
                acc_ext = {acc_al[ACCW-1], acc_al};
                p_ext   = {{(ACCW+1-PW){1'b0}}, p_al};
                sum     = sgn_p1_q[i] ? (acc_ext - p_ext) : (acc_ext + p_ext);
                ovf     = sum[ACCW] ^ sum[ACCW-1];
                p_load  = {{(ACCW-PW){1'b0}}, prod_p1_q[i]};

                if (zero_p1_q[i]) begin
                    acc_post = acc_q[i];
                    exp_post = exp_q[i];
                    emp_post = empty_q[i];
                end else if (empty_q[i]) begin
                    acc_post = sgn_p1_q[i] ? -p_load : p_load;
                    exp_post = exp_p1_q[i];
                    emp_post = 1'b0;
                end else begin
                    acc_post = renorm(sum);
                    exp_post = e_new + {{(XW-1){1'b0}}, ovf};
                    emp_post = 1'b0;
                end

                if (last_p1_q) begin
                    out_acc_d[i*ACCW +: ACCW] = acc_post;
                    out_exp_d[i*XW +: XW]     = exp_post;
                    acc_d[i]   = '0;
                    exp_d[i]   = '0;
                    empty_d[i] = 1'b1;
                end else begin
                    acc_d[i]   = acc_post;
                    exp_d[i]   = exp_post;
                    empty_d[i] = emp_post;
                end
            end
            if (last_p1_q) out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1_q    <= 1'b0;
            last_p1_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_exp_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
                prod_p1_q[i] <= '0;
                exp_p1_q[i]  <= '0;
                sgn_p1_q[i]  <= 1'b0;
                zero_p1_q[i] <= 1'b0;
                acc_q[i]     <= '0;
                exp_q[i]     <= '0;
                empty_q[i]   <= 1'b1;
            end
        end else begin
            vld_p1_q    <= vld_p1_d;
            last_p1_q   <= last_p1_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_exp_q   <= out_exp_d;
            prod_p1_q   <= prod_p1_d;
            exp_p1_q    <= exp_p1_d;
            sgn_p1_q    <= sgn_p1_d;
            zero_p1_q   <= zero_p1_d;
            acc_q       <= acc_d;
            exp_q       <= exp_d;
            empty_q     <= empty_d;
        end
    end

endmodule
